// File: rtl/servant_arb_pkg.sv
// servant_arb_pkg: shared types and constants for the servant RAM arbiter
package servant_arb_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;
  localparam logic ARB_IBUS = 1'b0;
  localparam logic ARB_DBUS = 1'b1;
  localparam logic [3:0] ARB_TIMEOUT = 4'd15;
  localparam logic [31:0] ARB_DEADBEEF = 32'hdeadbeef;
endpackage

// File: rtl/servant_rr_pick.sv
// servant_rr_pick: combinational 2-way round-robin pick, the master not served last wins a tie
module servant_rr_pick
  import servant_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant
);
  // a lone requester always wins; a tie goes to whoever was not served last
  always_comb o_grant = (&i_req) ? ~i_last : i_req[ARB_DBUS];
endmodule

// File: rtl/servant_ram_arbiter.sv
// servant_ram_arbiter: shares one Wishbone RAM slave between ibus and dbus; optional SERVANT_ARB_TIMEOUT_EN adds a 15-cycle ack timeout
module servant_ram_arbiter
  import servant_arb_pkg::*;
#(
  parameter int aw = 10
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [aw-3:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [aw-3:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack
);
  arb_state_e state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic pick, busy, done, tmo;

  servant_rr_pick u_pick (
    .i_req  ({i_dbus_cyc, i_ibus_cyc}),
    .i_last (last_q),
    .o_grant(pick)
  );

  // reset gates the slave cycle immediately so an aborted access never acks
  assign busy = (state_q == BUSY) && !i_wb_rst;
  assign done = busy && (i_wb_ack || tmo);

`ifdef SERVANT_ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  // cycles spent in BUSY; zero on the first BUSY cycle
  always_comb cnt_d = (state_q == BUSY) ? cnt_q + 4'd1 : 4'd0;
  // timeout counter register
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
  assign tmo = busy && !i_wb_ack && (cnt_q == ARB_TIMEOUT);
`else
  assign tmo = 1'b0;
`endif

  // next state: grant on any request in IDLE, release on ack (or timeout)
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && (i_ibus_cyc || i_dbus_cyc)) begin
      state_d = BUSY;
      grant_d = pick;
    end else if (done) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end

  // arbiter state registers; ibus wins the first tie after reset
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= IDLE;
      grant_q <= ARB_IBUS;
      last_q  <= ARB_DBUS;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // slave request mux from the granted master; ibus is a plain word read
  always_comb begin
    o_wb_cyc   = busy;
    o_wb_adr   = !busy ? '0 : (grant_q == ARB_DBUS) ? i_dbus_adr : i_ibus_adr;
    o_wb_dat   = (busy && grant_q == ARB_DBUS) ? i_dbus_dat : 32'h0;
    o_wb_sel   = !busy ? 4'h0 : (grant_q == ARB_DBUS) ? i_dbus_sel : 4'hf;
    o_wb_we    = busy && (grant_q == ARB_DBUS) && i_dbus_we;
    o_ibus_ack = done && (grant_q == ARB_IBUS);
    o_dbus_ack = done && (grant_q == ARB_DBUS);
    o_ibus_rdt = tmo ? ARB_DEADBEEF : i_wb_rdt;
    o_dbus_rdt = tmo ? ARB_DEADBEEF : i_wb_rdt;
  end
endmodule
